// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a valid/ready memory port.
// Optional multiply/divide support is enabled by defining MDU_EN.
module mc_controller #(
    parameter int SEL_W   = 3,
    parameter int ALUOP_W = 6,
    parameter int MDU_LAT = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               memReady,
    output logic               memReq,
    output logic               memWrite,
    output logic [SEL_W-1:0]   memAdrChoose,
    output logic               irWE,
    output logic               pcWE,
    output logic [SEL_W-1:0]   npcChoose,
    output logic [SEL_W-1:0]   wtChoose,
    output logic [SEL_W-1:0]   wdataChoose,
    output logic [SEL_W-1:0]   BChoose,
    output logic [ALUOP_W-1:0] aluOp,
    output logic               grfWE,
    output logic               mduStart,
    output logic [1:0]         mduOp,
    output logic [2:0]         state,
    output logic               illegal
);

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        EXEC     = 3'd2,
        MEM      = 3'd3,
        WB       = 3'd4,
        MDU_WAIT = 3'd5
    } state_t;

    localparam int CNT_W = $clog2(MDU_LAT + 1);

`ifdef MDU_EN
    localparam bit MDU_ON = 1'b1;
`else
    localparam bit MDU_ON = 1'b0;
`endif

    state_t             state_reg, state_next;
    logic               illegal_reg;
    logic [CNT_W-1:0]   mdu_cnt_reg, mdu_cnt_next;

    logic rtype;
    logic is_add, is_sub, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal;
    logic is_mult, is_div, is_mfhi, is_mflo, is_mdu, is_legal;

    assign rtype   = (opcode == 6'b000000);
    assign is_add  = rtype && (func == 6'b100000);
    assign is_sub  = rtype && (func == 6'b100010);
    assign is_jr   = rtype && (func == 6'b001000);
    assign is_ori  = (opcode == 6'b001101);
    assign is_lui  = (opcode == 6'b001111);
    assign is_lw   = (opcode == 6'b100011);
    assign is_sw   = (opcode == 6'b101011);
    assign is_beq  = (opcode == 6'b000100);
    assign is_jal  = (opcode == 6'b000011);
    // Without the MDU these decode to 0 and therefore fall into the illegal set.
    assign is_mult = MDU_ON && rtype && (func == 6'b011000);
    assign is_div  = MDU_ON && rtype && (func == 6'b011010);
    assign is_mfhi = MDU_ON && rtype && (func == 6'b010000);
    assign is_mflo = MDU_ON && rtype && (func == 6'b010010);
    assign is_mdu  = is_mult || is_div;
    assign is_legal = is_add || is_sub || is_jr || is_ori || is_lui || is_lw || is_sw ||
                      is_beq || is_jal || is_mdu || is_mfhi || is_mflo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= FETCH;
            illegal_reg <= 1'b0;
            mdu_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            mdu_cnt_reg <= mdu_cnt_next;
            if (state_reg == DECODE && !is_legal)
                illegal_reg <= 1'b1;
        end
    end

    // Outputs are gated by reset_n so nothing, not even memReq, is asserted while reset is held.
    always_comb begin
        state_next   = state_reg;
        mdu_cnt_next = mdu_cnt_reg;
        memReq       = 1'b0;
        memWrite     = 1'b0;
        memAdrChoose = '0;
        irWE         = 1'b0;
        pcWE         = 1'b0;
        npcChoose    = '0;
        wtChoose     = '0;
        wdataChoose  = '0;
        BChoose      = '0;
        aluOp        = '0;
        grfWE        = 1'b0;
        mduStart     = 1'b0;
        mduOp        = 2'd0;
        if (reset_n) begin
            case (state_reg)
                FETCH: begin
                    memReq = 1'b1;
                    if (memReady) begin
                        irWE       = 1'b1;
                        pcWE       = 1'b1;
                        state_next = DECODE;
                    end
                end
                DECODE: state_next = is_legal ? EXEC : FETCH;
                EXEC: begin
                    state_next = FETCH;
                    if (is_add || is_sub) begin
                        aluOp      = is_sub ? ALUOP_W'(1) : ALUOP_W'(0);
                        state_next = WB;
                    end else if (is_ori || is_lui) begin
                        BChoose    = SEL_W'(1);
                        aluOp      = is_lui ? ALUOP_W'(3) : ALUOP_W'(2);
                        state_next = WB;
                    end else if (is_lw || is_sw) begin
                        BChoose    = SEL_W'(2);
                        state_next = MEM;
                    end else if (is_beq) begin
                        aluOp     = ALUOP_W'(1);
                        pcWE      = zero;
                        npcChoose = SEL_W'(1);
                    end else if (is_jal) begin
                        grfWE       = 1'b1;
                        wtChoose    = SEL_W'(2);
                        wdataChoose = SEL_W'(2);
                        pcWE        = 1'b1;
                        npcChoose   = SEL_W'(2);
                    end else if (is_jr) begin
                        pcWE      = 1'b1;
                        npcChoose = SEL_W'(3);
                    end else if (is_mdu) begin
                        mduStart     = 1'b1;
                        mduOp        = {1'b0, is_div};
                        mdu_cnt_next = CNT_W'(MDU_LAT - 1);
                        state_next   = MDU_WAIT;
                    end else if (is_mfhi || is_mflo) begin
                        state_next = WB;
                    end
                end
                MEM: begin
                    memReq       = 1'b1;
                    memAdrChoose = SEL_W'(1);
                    memWrite     = is_sw;
                    if (memReady)
                        state_next = is_lw ? WB : FETCH;
                end
                WB: begin
                    grfWE      = 1'b1;
                    wtChoose   = rtype ? SEL_W'(1) : SEL_W'(0);
                    if (is_lw)
                        wdataChoose = SEL_W'(1);
                    else if (is_mfhi)
                        wdataChoose = SEL_W'(3);
                    else if (is_mflo)
                        wdataChoose = SEL_W'(4);
                    state_next = FETCH;
                end
                MDU_WAIT: begin
                    if (mdu_cnt_reg == '0)
                        state_next = FETCH;
                    else
                        mdu_cnt_next = mdu_cnt_reg - 1'b1;
                end
                default: state_next = FETCH;
            endcase
        end
    end

    assign state   = state_reg;
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instruction table with a result scoreboard,
// plus hand sequences for reset, the add state trace and reset during a store.
module tb_mc_controller;

    logic       clk, reset_n;
    logic [5:0] opcode, func;
    logic       zero, memReady;
    logic       memReq, memWrite, irWE, pcWE, grfWE, mduStart, illegal;
    logic [2:0] memAdrChoose, npcChoose, wtChoose, wdataChoose, BChoose, state;
    logic [5:0] aluOp;
    logic [1:0] mduOp;

    mc_controller dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func), .zero(zero),
        .memReady(memReady), .memReq(memReq), .memWrite(memWrite),
        .memAdrChoose(memAdrChoose), .irWE(irWE), .pcWE(pcWE), .npcChoose(npcChoose),
        .wtChoose(wtChoose), .wdataChoose(wdataChoose), .BChoose(BChoose), .aluOp(aluOp),
        .grfWE(grfWE), .mduStart(mduStart), .mduOp(mduOp), .state(state), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op, fn;
        logic       z;
        int         fs, ms;      // memReady-low cycles in FETCH / MEM
        int         cyc, grf;
        logic [2:0] wt, wd;
        int         pcw;
        logic [2:0] npc;
        int         memw, madr;
        logic [2:0] bch;
        logic [5:0] aop;
        int         mds;
        logic       ill;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic ill_model = 1'b0;
    vec_t exp_q[$];
    vec_t tbl[$];
    logic [2:0] st_q[$];
    logic       grf_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input int fs, input int ms, input int cyc, input int grf,
                                input logic [2:0] wt, input logic [2:0] wd, input int pcw,
                                input logic [2:0] npc, input int memw, input int madr,
                                input logic [2:0] bch, input logic [5:0] aop,
                                input int mds, input logic ill);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.fs = fs; v.ms = ms; v.cyc = cyc; v.grf = grf;
        v.wt = wt; v.wd = wd; v.pcw = pcw; v.npc = npc; v.memw = memw; v.madr = madr;
        v.bch = bch; v.aop = aop; v.mds = mds; v.ill = ill;
        return v;
    endfunction

    // Starts at a negedge in FETCH, ends at the negedge of the next instruction's FETCH.
    task automatic run_vec(input vec_t v);
        vec_t e;
        int cyc = 0, grf = 0, pcw = 0, memw = 0, madr = 0, mds = 0, fs, ms;
        logic [2:0] wt = 0, wd = 0, npc = 0, bch = 0, st;
        logic [5:0] aop = 0;
        logic done = 1'b0;
        opcode = v.op; func = v.fn; zero = v.z; fs = v.fs; ms = v.ms;
        ill_model = ill_model | v.ill;
        e = v; e.ill = ill_model;
        exp_q.push_back(e);
        for (int k = 0; k < 40; k++) begin
            st = state;
            memReady = 1'b1;
            if (st == 3'd0 && fs > 0) begin memReady = 1'b0; fs--; end
            if (st == 3'd3 && ms > 0) begin memReady = 1'b0; ms--; end
            #1;
            cyc++;
            if (grfWE) begin grf++; wt = wtChoose; wd = wdataChoose; end
            if (pcWE) begin pcw++; npc = npcChoose; end
            if (memWrite) memw++;
            if (memReq && memAdrChoose == 3'd1) madr++;
            if (mduStart) mds++;
            if (st == 3'd2) begin bch = BChoose; aop = aluOp; end
            @(negedge clk);
            if (state == 3'd0 && st != 3'd0) begin done = 1'b1; break; end
        end
        e = exp_q.pop_front();
        chk("done", {31'd0, done}, 32'd1);
        chk("cycles", cyc, e.cyc);
        chk("grfWE_pulses", grf, e.grf);
        chk("wtChoose", {29'd0, wt}, {29'd0, e.wt});
        chk("wdataChoose", {29'd0, wd}, {29'd0, e.wd});
        chk("pcWE_pulses", pcw, e.pcw);
        chk("npcChoose", {29'd0, npc}, {29'd0, e.npc});
        chk("memWrite_cycles", memw, e.memw);
        chk("memAdr1_cycles", madr, e.madr);
        chk("BChoose", {29'd0, bch}, {29'd0, e.bch});
        chk("aluOp", {26'd0, aop}, {26'd0, e.aop});
        chk("mduStart_pulses", mds, e.mds);
        chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
        $display("instr op=%b fn=%b z=%0d cycles=%0d grf=%0d pcw=%0d illegal=%0d",
                 v.op, v.fn, v.z, cyc, grf, pcw, illegal);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            op         fn        z fs ms cyc grf wt wd pcw npc mw madr bch aop mds ill
        tbl.push_back(mk(6'b000000, 6'b100000, 0, 0, 0, 4, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // add
        tbl.push_back(mk(6'b000000, 6'b100010, 0, 0, 0, 4, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0)); // sub
        tbl.push_back(mk(6'b001101, 6'b000000, 0, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, 1, 2, 0, 0)); // ori
        tbl.push_back(mk(6'b001111, 6'b000000, 0, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, 1, 3, 0, 0)); // lui
        tbl.push_back(mk(6'b100011, 6'b000000, 0, 0, 2, 7, 1, 0, 1, 1, 0, 0, 3, 2, 0, 0, 0)); // lw, MEM stall 2
        tbl.push_back(mk(6'b100011, 6'b000000, 0, 1, 0, 6, 1, 0, 1, 1, 0, 0, 1, 2, 0, 0, 0)); // lw, FETCH stall 1
        tbl.push_back(mk(6'b101011, 6'b000000, 0, 0, 0, 4, 0, 0, 0, 1, 0, 1, 1, 2, 0, 0, 0)); // sw
        tbl.push_back(mk(6'b101011, 6'b000000, 0, 0, 1, 5, 0, 0, 0, 1, 0, 2, 2, 2, 0, 0, 0)); // sw, MEM stall 1
        tbl.push_back(mk(6'b000100, 6'b000000, 1, 0, 0, 3, 0, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0)); // beq taken
        tbl.push_back(mk(6'b000100, 6'b000000, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0)); // beq not taken
        tbl.push_back(mk(6'b000011, 6'b000000, 0, 0, 0, 3, 1, 2, 2, 2, 2, 0, 0, 0, 0, 0, 0)); // jal
        tbl.push_back(mk(6'b000000, 6'b001000, 0, 0, 0, 3, 0, 0, 0, 2, 3, 0, 0, 0, 0, 0, 0)); // jr
`ifdef MDU_EN
        tbl.push_back(mk(6'b000000, 6'b011000, 0, 0, 0, 8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0)); // mult
        tbl.push_back(mk(6'b000000, 6'b010000, 0, 0, 0, 4, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0)); // mfhi
        tbl.push_back(mk(6'b000000, 6'b010010, 0, 0, 0, 4, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0)); // mflo
`else
        tbl.push_back(mk(6'b000000, 6'b011000, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1)); // mult illegal
        tbl.push_back(mk(6'b000000, 6'b010000, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1)); // mfhi illegal
`endif
        tbl.push_back(mk(6'b111111, 6'b000000, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1)); // bad opcode
        tbl.push_back(mk(6'b000000, 6'b000000, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1)); // bad func
        tbl.push_back(mk(6'b000000, 6'b100000, 0, 0, 0, 4, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // add, illegal stays set

        // Reset held: every output low.
        reset_n = 1'b0; memReady = 1'b1; opcode = 6'd0; func = 6'b100000; zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {14'd0, memReq, memWrite, irWE, pcWE, grfWE, mduStart, illegal,
                              memAdrChoose, npcChoose, wtChoose, wdataChoose, BChoose},
            32'd0);
        chk("reset_misc", {23'd0, state, aluOp}, 32'd0);
        @(negedge clk);
        memReady = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("memReq_after_reset", {31'd0, memReq}, 32'd1);
        chk("irWE_no_ready", {31'd0, irWE}, 32'd0);
        @(negedge clk);

        // add state trace 0,1,2,4 then back to 0; grfWE only in cycle 4 with wtChoose=1.
        opcode = 6'b000000; func = 6'b100000; memReady = 1'b1;
        st_q = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        grf_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            logic [2:0] es;
            logic eg;
            es = st_q.pop_front();
            eg = grf_q.pop_front();
            #1;
            chk("add_state", {29'd0, state}, {29'd0, es});
            chk("add_grfWE", {31'd0, grfWE}, {31'd0, eg});
            if (eg) chk("add_wtChoose", {29'd0, wtChoose}, 32'd1);
            if (i < 4) @(negedge clk);
        end
        memReady = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset in the middle of a store's MEM phase.
        opcode = 6'b101011; func = 6'd0; memReady = 1'b1;
        for (int k = 0; k < 10 && state != 3'd3; k++) @(negedge clk);
        memReady = 1'b0;
        #1;
        chk("sw_mem_memWrite", {31'd0, memWrite}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_memWrite", {31'd0, memWrite}, 32'd0);
        chk("abort_state", {29'd0, state}, 32'd0);
        chk("abort_memReq", {31'd0, memReq}, 32'd0);
        chk("abort_illegal", {31'd0, illegal}, 32'd0);
        ill_model = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        begin
            int g = 0;
            for (int k = 0; k < 3; k++) begin
                #1;
                if (grfWE || memWrite) g++;
                @(negedge clk);
            end
            chk("abort_no_write", g, 0);
        end
        run_vec(tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
